audio_i2s_tx: RTL and testbench



---
 rtl/audio_i2s_tx.sv | 195 +++++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo PCM to I2S serializer with a 2-entry sample FIFO and
// PLL-lock qualification.
//
// Ports:
//   clk, rst          audio clock, asynchronous active-high reset
//   pll_locked        PLL lock indicator (synchronous to clk)
//   s_valid/s_ready   sample-pair handshake; s_left/s_right two's complement
//   i2s_bclk          bit clock, clk / BCLK_DIV
//   i2s_lrclk         word select (0 = left, 1 = right)
//   i2s_sdata         serial data, MSB first, one BCLK after each LRCLK edge
//   frame_start       one-cycle pulse in the first cycle of each frame
//   underrun          one-cycle pulse, coincident with frame_start, when the
//                     frame just loaded found the FIFO empty
//
// All outputs are registered from the next-cycle counter/frame values, so an
// output observed in a cycle corresponds to the counters of that same cycle.
module audio_i2s_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BCLK_DIV  = 8,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata,
    output logic              frame_start,
    output logic              underrun
);

    localparam int unsigned PAIR_W  = 2 * DATA_W;
    localparam int unsigned DIV_W   = $clog2(BCLK_DIV);
    localparam int unsigned LOCK_W  = $clog2(LOCK_WAIT);
    localparam int unsigned HALF    = BCLK_DIV / 2;
    localparam int unsigned DIV_MAX = BCLK_DIV - 1;
    localparam int unsigned LOCK_MAX = LOCK_WAIT - 1;
    localparam int unsigned R_BASE  = DATA_W + 32;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [PAIR_W-1:0]   fifo_q [2];
    logic [PAIR_W-1:0]   fifo_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [PAIR_W-1:0]   frame_q, frame_d;
    logic                bclk_d, lrclk_d, sdata_d, frame_start_d, underrun_d, s_ready_d;
    logic                push_c, load_c, pop_c;
    logic [PAIR_W-1:0]   shifted_c;

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        frame_d       = frame_q;
        bclk_d        = 1'b0;
        lrclk_d       = 1'b0;
        sdata_d       = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        s_ready_d     = 1'b0;
        shifted_c     = '0;
        push_c        = s_valid && s_ready;
        load_c        = 1'b0;
        pop_c         = 1'b0;

        // Lock qualification state machine
        if (state_q == WAIT_LOCK) begin
            if (pll_locked) begin
                if (lock_cnt_q == LOCK_W'(LOCK_MAX)) begin
                    state_d    = RUN;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end else begin
                lock_cnt_d = '0;
            end
        end else begin
            lock_cnt_d = '0;
            if (!pll_locked) begin
                state_d = WAIT_LOCK;
            end
        end

        if (state_d == WAIT_LOCK) begin
            // Flush everything; any in-flight push is discarded too
            div_cnt_d = '0;
            bit_cnt_d = '0;
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            count_d   = '0;
            frame_d   = '0;
        end else begin
            if (state_q == RUN) begin
                load_c = (bit_cnt_q == 6'd63) && (div_cnt_q == DIV_W'(DIV_MAX));
                pop_c  = load_c && (count_q != 2'd0);
                if (div_cnt_q == DIV_W'(DIV_MAX)) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
                if (push_c) begin
                    fifo_d[wr_ptr_q] = {s_left, s_right};
                    wr_ptr_d         = ~wr_ptr_q;
                end
                if (load_c) begin
                    frame_d = pop_c ? fifo_q[rd_ptr_q] : '0;
                end
                if (pop_c) begin
                    rd_ptr_d = ~rd_ptr_q;
                end
                count_d = count_q + 2'(push_c) - 2'(pop_c);
            end else begin
                // First RUN cycle: counters start from zero with an empty frame
                div_cnt_d = '0;
                bit_cnt_d = '0;
            end

            // Left bits at slots 1..DATA_W, right bits at 33..32+DATA_W
            if (bit_cnt_d >= 6'd1 && bit_cnt_d <= 6'(DATA_W)) begin
                shifted_c = frame_d >> (PAIR_W - 32'(bit_cnt_d));
            end else if (bit_cnt_d >= 6'd33 && bit_cnt_d <= 6'(R_BASE)) begin
                shifted_c = frame_d >> (R_BASE - 32'(bit_cnt_d));
            end

            bclk_d        = (div_cnt_d >= DIV_W'(HALF));
            lrclk_d       = bit_cnt_d[5];
            sdata_d       = shifted_c[0];
            frame_start_d = (bit_cnt_d == 6'd0) && (div_cnt_d == '0);
            underrun_d    = load_c && !pop_c;
            s_ready_d     = (count_d != 2'd2);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            lock_cnt_q  <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            frame_q     <= '0;
            i2s_bclk    <= 1'b0;
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            s_ready     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_q     <= frame_d;
            i2s_bclk    <= bclk_d;
            i2s_lrclk   <= lrclk_d;
            i2s_sdata   <= sdata_d;
            frame_start <= frame_start_d;
            underrun    <= underrun_d;
            s_ready     <= s_ready_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by count/pointers
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed testbench for audio_i2s_tx with default parameters
// (DATA_W=16, BCLK_DIV=8, LOCK_WAIT=1024). Outputs are sampled on the falling
// clk edge; inputs are driven on the falling edge.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        pll_locked;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_start;
    logic        underrun;

    audio_i2s_tx dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-frame capture results
    logic [31:0] cap_left, cap_right;
    logic [63:0] lr_bits;
    int          bclk_high, bclk_rises, ur_pulses, fs_pulses, push_cnt;
    int          last_rise = -1;
    int          lr_rise_cyc;
    bit          bclk_per_bad;
    logic        sready_10;
    bit          inc_mode = 1'b0;
    logic [15:0] val;

    // Wait (bounded) for the first frame_start; n = negedges waited
    task automatic wait_run(output int n, output bit ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (n < 1100) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
            if (s_ready) ready_seen = 1'b1;
        end
    endtask

    // Observe one 512-cycle frame starting at its cycle 0; ends at next cycle 0
    task automatic capture_frame();
        logic prev_bclk, prev_lr, pushed;
        cap_left = '0; cap_right = '0; lr_bits = '0;
        bclk_high = 0; bclk_rises = 0; ur_pulses = 0; fs_pulses = 0; push_cnt = 0;
        bclk_per_bad = 1'b0; sready_10 = 1'bx;
        prev_bclk = i2s_bclk;
        prev_lr = i2s_lrclk;
        for (int i = 0; i < 512; i++) begin
            if (i % 8 == 4) begin
                if (i < 256) cap_left = {cap_left[30:0], i2s_sdata};
                else         cap_right = {cap_right[30:0], i2s_sdata};
                lr_bits = {lr_bits[62:0], i2s_lrclk};
            end
            if (i == 10) sready_10 = s_ready;
            if (i2s_bclk) bclk_high++;
            if (i2s_bclk && !prev_bclk) begin
                if (last_rise >= 0 && cyc - last_rise != 8) bclk_per_bad = 1'b1;
                last_rise = cyc;
                bclk_rises++;
            end
            if (i2s_lrclk && !prev_lr) lr_rise_cyc = cyc;
            prev_bclk = i2s_bclk;
            prev_lr = i2s_lrclk;
            if (underrun) ur_pulses++;
            if (frame_start) fs_pulses++;
            pushed = s_valid && s_ready;
            if (pushed) push_cnt++;
            @(negedge clk);
            if (pushed) begin
                if (inc_mode) begin
                    val = val + 16'd1;
                    s_left = val;
                    s_right = ~val;
                end else begin
                    s_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) @(negedge clk);
        checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b exp 0", i2s_bclk); end
        checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk got %b exp 0", i2s_lrclk); end
        checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata got %b exp 0", i2s_sdata); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        checks++; if ({frame_start, underrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {frame_start, underrun}); end
        rst = 1'b0;
    endtask

    task automatic test_lock_qual();
        int n;
        bit rs, early;
        early = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (s_ready || frame_start) early = 1'b1;
        end
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_run(n, rs);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL lock_early_run got %b exp 0", early); end
        checks++; if (n !== 1024) begin errors++; $display("FAIL lock_first_frame_start got %0d exp 1024", n); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL lock_s_ready_during_wait got %b exp 0", rs); end
    endtask

    task automatic test_single_frame();
        logic [31:0] exp_l, exp_r;
        int lr1;
        exp_l = {1'b0, 16'hA5C3, 15'h0};
        exp_r = {1'b0, 16'h0F81, 15'h0};
        // Frame 1: first RUN frame, push one pair
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL f1_s_ready got %b exp 1", s_ready); end
        s_valid = 1'b1; s_left = 16'hA5C3; s_right = 16'h0F81;
        capture_frame();
        checks++; if (ur_pulses !== 0) begin errors++; $display("FAIL f1_underrun got %0d exp 0", ur_pulses); end
        checks++; if ({cap_left, cap_right} !== 64'h0) begin errors++; $display("FAIL f1_data got %h exp 0", {cap_left, cap_right}); end
        checks++; if (push_cnt !== 1) begin errors++; $display("FAIL f1_push_cnt got %0d exp 1", push_cnt); end
        // Frame 2: pair appears
        last_rise = -1;
        capture_frame();
        lr1 = lr_rise_cyc;
        checks++; if (fs_pulses !== 1) begin errors++; $display("FAIL f2_frame_start got %0d exp 1", fs_pulses); end
        checks++; if (ur_pulses !== 0) begin errors++; $display("FAIL f2_underrun got %0d exp 0", ur_pulses); end
        checks++; if (cap_left !== exp_l) begin errors++; $display("FAIL f2_left got %h exp %h", cap_left, exp_l); end
        checks++; if (cap_right !== exp_r) begin errors++; $display("FAIL f2_right got %h exp %h", cap_right, exp_r); end
        checks++; if (lr_bits !== {32'h0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL f2_lrclk got %h exp 00000000ffffffff", lr_bits); end
        checks++; if (bclk_high !== 256) begin errors++; $display("FAIL f2_bclk_duty got %0d exp 256", bclk_high); end
        checks++; if (bclk_rises !== 64) begin errors++; $display("FAIL f2_bclk_rises got %0d exp 64", bclk_rises); end
        checks++; if (bclk_per_bad !== 1'b0) begin errors++; $display("FAIL f2_bclk_period got %b exp 0", bclk_per_bad); end
        // Frame 3 starts underrun test; check LRCLK period across frames
        capture_frame();
        checks++; if (lr_rise_cyc - lr1 !== 512) begin errors++; $display("FAIL lrclk_period got %0d exp 512", lr_rise_cyc - lr1); end
        checks++; if (fs_pulses !== 1) begin errors++; $display("FAIL f3_frame_start got %0d exp 1", fs_pulses); end
    endtask

    task automatic test_underrun();
        // Frame 3 already captured by test_single_frame
        checks++; if ({cap_left, cap_right} !== 64'h0) begin errors++; $display("FAIL f3_zero_data got %h exp 0", {cap_left, cap_right}); end
        checks++; if (ur_pulses !== 1) begin errors++; $display("FAIL f3_underrun got %0d exp 1", ur_pulses); end
        capture_frame();
        checks++; if (ur_pulses !== 1) begin errors++; $display("FAIL f4_underrun got %0d exp 1", ur_pulses); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_v;
        val = 16'd0; s_left = 16'd0; s_right = 16'hFFFF; s_valid = 1'b1; inc_mode = 1'b1;
        // Frame 5: outputs zeros (empty load), FIFO fills with 0 and 1
        capture_frame();
        checks++; if (push_cnt !== 2) begin errors++; $display("FAIL f5_push_cnt got %0d exp 2", push_cnt); end
        checks++; if (sready_10 !== 1'b0) begin errors++; $display("FAIL f5_s_ready_full got %b exp 0", sready_10); end
        checks++; if (ur_pulses !== 1) begin errors++; $display("FAIL f5_underrun got %0d exp 1", ur_pulses); end
        exp_v = 16'd0;
        for (int f = 6; f <= 8; f++) begin
            capture_frame();
            checks++; if ({cap_left[30:15], cap_right[30:15]} !== {exp_v, ~exp_v}) begin
                errors++; $display("FAIL bp_frame%0d_data got %h exp %h", f, {cap_left[30:15], cap_right[30:15]}, {exp_v, ~exp_v});
            end
            checks++; if (push_cnt !== 1) begin errors++; $display("FAIL bp_frame%0d_push_cnt got %0d exp 1", f, push_cnt); end
            checks++; if (ur_pulses !== 0) begin errors++; $display("FAIL bp_frame%0d_underrun got %0d exp 0", f, ur_pulses); end
            exp_v = exp_v + 16'd1;
        end
    endtask

    task automatic test_lock_loss();
        int n;
        bit rs;
        // Frame 9 cycle 0: one more push fills the FIFO to 2
        inc_mode = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (163) @(negedge clk);   // cycle 164: bit_cnt=20, BCLK high
        checks++; if (i2s_bclk !== 1'b1) begin errors++; $display("FAIL ll_bclk_before got %b exp 1", i2s_bclk); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ll_fifo_full got %b exp 0", s_ready); end
        pll_locked = 1'b0;
        @(negedge clk);
        checks++; if ({i2s_bclk, i2s_lrclk, i2s_sdata, s_ready} !== 4'b0000) begin
            errors++; $display("FAIL ll_outputs_idle got %b exp 0000", {i2s_bclk, i2s_lrclk, i2s_sdata, s_ready});
        end
        pll_locked = 1'b1;
        wait_run(n, rs);
        checks++; if (n !== 1024) begin errors++; $display("FAIL ll_relock_wait got %0d exp 1024", n); end
        capture_frame();
        checks++; if ({cap_left, cap_right} !== 64'h0) begin errors++; $display("FAIL ll_first_frame got %h exp 0", {cap_left, cap_right}); end
        checks++; if (ur_pulses !== 0) begin errors++; $display("FAIL ll_first_underrun got %0d exp 0", ur_pulses); end
        capture_frame();
        checks++; if ({cap_left, cap_right} !== 64'h0) begin errors++; $display("FAIL ll_second_frame got %h exp 0", {cap_left, cap_right}); end
        checks++; if (ur_pulses !== 1) begin errors++; $display("FAIL ll_second_underrun got %0d exp 1", ur_pulses); end
    endtask

    task automatic test_async_reset();
        int n;
        bit rs;
        repeat (100) @(negedge clk);   // cycle 100 of a frame: BCLK high
        checks++; if ({i2s_bclk, s_ready} !== 2'b11) begin errors++; $display("FAIL ar_before got %b exp 11", {i2s_bclk, s_ready}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({i2s_bclk, i2s_lrclk, i2s_sdata, s_ready, frame_start, underrun} !== 6'b0) begin
            errors++; $display("FAIL ar_outputs got %b exp 000000", {i2s_bclk, i2s_lrclk, i2s_sdata, s_ready, frame_start, underrun});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_run(n, rs);
        checks++; if (n !== 1024) begin errors++; $display("FAIL ar_relock_wait got %0d exp 1024", n); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL ar_s_ready_during_wait got %b exp 0", rs); end
    endtask

    initial begin
        test_reset();
        test_lock_qual();
        test_single_frame();
        test_underrun();
        test_backpressure();
        test_lock_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
